// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array feed controller: FSM encoding,
// counter width and the drain-length rule.
package systolic_pkg;

    localparam int KW = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Drain covers lane skew (N-1) plus array propagation (2N-1) plus 2 cycles of margin: 3N total.
    function automatic logic [KW-1:0] drain_len(input int unsigned n);
        logic [31:0] v;
        v = 32'd3 * n;
        return v[KW-1:0];
    endfunction

endpackage

// File: rtl/skew_delay.sv
// Reset-clearable data+valid delay line used to skew one array-edge lane.
// DEPTH=0 is a combinational pass-through.
module skew_delay #(
    parameter int DEPTH = 0,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_valid,
    input  logic [DW-1:0] i_data,
    output logic          o_valid,
    output logic [DW-1:0] o_data
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic w_unused_ok;
            assign w_unused_ok = &{1'b0, clk, rst};
            assign o_valid     = i_valid;
            assign o_data      = i_valid ? i_data : {DW{1'b0}};
        end else begin : g_shift
            logic [DEPTH-1:0] r_vld;
            logic [DW-1:0]    r_data [DEPTH];

            // Shift stages; data is forced to zero whenever its valid is low.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_vld <= {DEPTH{1'b0}};
                    for (int s = 0; s < DEPTH; s++) begin
                        r_data[s] <= {DW{1'b0}};
                    end
                end else begin
                    r_vld[0]  <= i_valid;
                    r_data[0] <= i_valid ? i_data : {DW{1'b0}};
                    for (int s = 1; s < DEPTH; s++) begin
                        r_vld[s]  <= r_vld[s-1];
                        r_data[s] <= r_data[s-1];
                    end
                end
            end

            assign o_valid = r_vld[DEPTH-1];
            assign o_data  = r_data[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/systolic_feed_ctrl.sv
// Feed controller for an N x N systolic array: sequences K operand reads,
// captures A/B data and skews lane i by i cycles onto the array edges.
module systolic_feed_ctrl
    import systolic_pkg::*;
#(
    parameter int N  = 4,
    parameter int DW = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       k_len,
    output logic              busy,
    output logic              done,
    output logic              acc_clear,
    output logic              mem_rd_en,
    output logic [15:0]       mem_rd_addr,
    input  logic [N*DW-1:0]   mem_rd_a,
    input  logic [N*DW-1:0]   mem_rd_b,
    output logic [N*DW-1:0]   a_out,
    output logic [N*DW-1:0]   b_out,
    output logic [N-1:0]      a_valid,
    output logic [N-1:0]      b_valid
);

    localparam logic [KW-1:0] DRAIN_LAST = drain_len(N) - 16'd1;

    state_t          r_state;
    logic [KW-1:0]   r_k_len;
    logic [KW-1:0]   r_k;
    logic [KW-1:0]   r_drain;
    logic            r_rd_d1;
    logic            r_cap_vld;
    logic [N*DW-1:0] r_cap_a;
    logic [N*DW-1:0] r_cap_b;

    state_t          w_state_nxt;
    logic [KW-1:0]   w_k_len_nxt;
    logic [KW-1:0]   w_k_nxt;
    logic [KW-1:0]   w_drain_nxt;
    logic            w_acc_clear;

    // Control state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_k_len <= 16'd0;
            r_k     <= 16'd0;
            r_drain <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_k_len <= w_k_len_nxt;
            r_k     <= w_k_nxt;
            r_drain <= w_drain_nxt;
        end
    end

    // Next-state and counter logic; start is only honoured in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_k_len_nxt = r_k_len;
        w_k_nxt     = r_k;
        w_drain_nxt = r_drain;
        w_acc_clear = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && rst) begin
                    w_acc_clear = 1'b1;
                    w_k_len_nxt = k_len;
                    w_k_nxt     = 16'd0;
                    w_drain_nxt = 16'd0;
                    w_state_nxt = (k_len == 16'd0) ? ST_DONE : ST_FEED;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FEED: begin
                // Terminal compare against k_len-1 keeps k_len=65535 from wrapping.
                if (r_k == (r_k_len - 16'd1)) begin
                    w_state_nxt = ST_DRAIN;
                    w_drain_nxt = 16'd0;
                end else begin
                    w_k_nxt = r_k + 16'd1;
                end
            end
            ST_DRAIN: begin
                if (r_drain == DRAIN_LAST) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_drain_nxt = r_drain + 16'd1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign busy        = (r_state != ST_IDLE);
    assign done        = (r_state == ST_DONE);
    assign mem_rd_en   = (r_state == ST_FEED);
    assign mem_rd_addr = mem_rd_en ? r_k : 16'd0;
    assign acc_clear   = w_acc_clear;

    // Read-data capture: buffer data lands one cycle after the strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_d1   <= 1'b0;
            r_cap_vld <= 1'b0;
            r_cap_a   <= {(N*DW){1'b0}};
            r_cap_b   <= {(N*DW){1'b0}};
        end else begin
            r_rd_d1   <= (r_state == ST_FEED);
            r_cap_vld <= r_rd_d1;
            r_cap_a   <= r_rd_d1 ? mem_rd_a : {(N*DW){1'b0}};
            r_cap_b   <= r_rd_d1 ? mem_rd_b : {(N*DW){1'b0}};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            skew_delay #(
                .DEPTH (gi),
                .DW    (DW)
            ) u_skew_a (
                .clk     (clk),
                .rst     (rst),
                .i_valid (r_cap_vld),
                .i_data  (r_cap_a[gi*DW +: DW]),
                .o_valid (a_valid[gi]),
                .o_data  (a_out[gi*DW +: DW])
            );

            skew_delay #(
                .DEPTH (gi),
                .DW    (DW)
            ) u_skew_b (
                .clk     (clk),
                .rst     (rst),
                .i_valid (r_cap_vld),
                .i_data  (r_cap_b[gi*DW +: DW]),
                .o_valid (b_valid[gi]),
                .o_data  (b_out[gi*DW +: DW])
            );
        end
    endgenerate

endmodule
